// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: sweeps a contiguous range of register-file entries
// through one read port and streams each entry out as (index, data) over a
// valid/ready interface. Intended for post-run state dumps and trace capture.
module regfile_dump_reader #(
  parameter int unsigned FIRST_REG    = 0,
  parameter int unsigned LAST_REG     = 31,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic        Abort,
  output logic [4:0]  Read_Register,
  input  logic [31:0] Read_Data,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Data,
  output logic [4:0]  Out_Index,
  output logic        Busy,
  output logic        Done
);

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);
  localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(READ_LATENCY);

  logic [1:0]        state_q,  state_n;
  logic [CNT_W-1:0]  cnt_q,    cnt_n;
  logic [IDX_W-1:0]  raddr_q,  raddr_n;
  logic              valid_q,  valid_n;
  logic [DATA_W-1:0] data_q,   data_n;
  logic [IDX_W-1:0]  index_q,  index_n;
  logic              done_q,   done_n;
  logic              busy_q,   busy_n;

  logic handshake_c;
  logic last_entry_c;

  assign handshake_c  = valid_q & Out_Ready;
  assign last_entry_c = (raddr_q == LAST_IDX);

  // Next-state and next-output logic; abort takes precedence over any handshake.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    raddr_n = raddr_q;
    valid_n = valid_q;
    data_n  = data_q;
    index_n = index_q;
    done_n  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          raddr_n = FIRST_IDX;
          cnt_n   = LAT_CNT;
          state_n = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (Abort) begin
          valid_n = 1'b0;
          state_n = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          data_n  = Read_Data;
          index_n = raddr_q;
          valid_n = 1'b1;
          state_n = ST_OUT;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end

      ST_OUT: begin
        if (Abort) begin
          valid_n = 1'b0;
          state_n = ST_IDLE;
        end else if (handshake_c) begin
          valid_n = 1'b0;
          if (last_entry_c) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            raddr_n = raddr_q + IDX_W'(1);
            cnt_n   = LAT_CNT;
            state_n = ST_WAIT;
          end
        end
      end

      default: begin
        valid_n = 1'b0;
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      raddr_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      raddr_q <= raddr_n;
      valid_q <= valid_n;
      data_q  <= data_n;
      index_q <= index_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
    end
  end

  assign Read_Register = raddr_q;
  assign Out_Valid     = valid_q;
  assign Out_Data      = data_q;
  assign Out_Index     = index_q;
  assign Busy          = busy_q;
  assign Done          = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a default-parameter instance (a_*)
// and a FIRST_REG=8/LAST_REG=10/READ_LATENCY=3 instance (b_*), each fed by a
// register-file model holding reg[i] = 0x1000 + i, read on the falling edge.
module tb_regfile_dump_reader;

  logic clk = 1'b0;
  logic rst;

  logic        a_start, a_abort, a_ready;
  logic [4:0]  a_rr, a_oi;
  logic [31:0] a_rd, a_od;
  logic        a_ov, a_busy, a_done;

  logic        b_start, b_abort, b_ready;
  logic [4:0]  b_rr, b_oi;
  logic [31:0] b_rd, b_od;
  logic        b_ov, b_busy, b_done;

  int n_checks = 0;
  int n_fail   = 0;
  int e;

  always #5 clk = ~clk;

  regfile_dump_reader u_a (
    .CLK(clk), .RST(rst), .Start(a_start), .Abort(a_abort),
    .Read_Register(a_rr), .Read_Data(a_rd), .Out_Valid(a_ov),
    .Out_Ready(a_ready), .Out_Data(a_od), .Out_Index(a_oi),
    .Busy(a_busy), .Done(a_done)
  );

  regfile_dump_reader #(.FIRST_REG(8), .LAST_REG(10), .READ_LATENCY(3)) u_b (
    .CLK(clk), .RST(rst), .Start(b_start), .Abort(b_abort),
    .Read_Register(b_rr), .Read_Data(b_rd), .Out_Valid(b_ov),
    .Out_Ready(b_ready), .Out_Data(b_od), .Out_Index(b_oi),
    .Busy(b_busy), .Done(b_done)
  );

  // Register-file read ports: registered data updates on the falling edge.
  always @(negedge clk) begin
    a_rd <= 32'h1000 + 32'(a_rr);
    b_rd <= 32'h1000 + 32'(b_rr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until the selected instance shows Out_Valid; edges = steps taken.
  task automatic next_valid(input bit sel, output int edges);
    logic v;
    edges = 0;
    do begin
      step();
      edges++;
      v = sel ? b_ov : a_ov;
    end while (!v && edges < 64);
    chk("valid_arrives", 32'(v), 32'd1);
  endtask

  // Full default sweep with Out_Ready=1; optionally pulse Start mid-sweep.
  task automatic full_sweep_a(input bit restart_mid);
    int ed;
    int pre;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    pre = 1;
    for (int i = 0; i < 32; i++) begin
      next_valid(1'b0, ed);
      chk(i == 0 ? "a_first_latency" : "a_gap", 32'(ed + pre), 32'd2);
      pre = 0;
      chk("a_index", 32'(a_oi), 32'(i));
      chk("a_data", a_od, 32'h1000 + 32'(i));
      chk("a_busy_in_sweep", 32'(a_busy), 32'd1);
      if (restart_mid && i == 4) begin
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        pre = 1;
      end
    end
    step();
    chk("a_done_pulse", 32'(a_done), 32'd1);
    chk("a_busy_at_done", 32'(a_busy), 32'd0);
    chk("a_valid_at_done", 32'(a_ov), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;
    step();
    step();
    chk("rst_rr", 32'(a_rr), 32'd0);
    chk("rst_valid", 32'(a_ov), 32'd0);
    chk("rst_data", a_od, 32'd0);
    chk("rst_index", 32'(a_oi), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    rst = 1'b0;
    step();

    // Narrow sweep 8..10 with latency 3: one entry every 4 cycles.
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_valid(1'b1, e);
      chk(i == 0 ? "b_first_latency" : "b_gap", 32'(i == 0 ? e + 1 : e), 32'd4);
      chk("b_index", 32'(b_oi), 32'(8 + i));
      chk("b_data", b_od, 32'h1008 + 32'(i));
    end
    step();
    chk("b_done_pulse", 32'(b_done), 32'd1);
    chk("b_busy_at_done", 32'(b_busy), 32'd0);
    step();
    chk("b_done_one_cycle", 32'(b_done), 32'd0);

    // Plain full sweep.
    full_sweep_a(1'b0);
    step();
    chk("a_done_one_cycle", 32'(a_done), 32'd0);
    chk("a_idle_after_sweep", 32'(a_busy), 32'd0);
    chk("a_rr_holds_idle", 32'(a_rr), 32'd31);

    // Backpressure on index 2.
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) next_valid(1'b0, e);
    chk("bp_index", 32'(a_oi), 32'd2);
    a_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid_held", 32'(a_ov), 32'd1);
      chk("bp_index_held", 32'(a_oi), 32'd2);
      chk("bp_data_held", a_od, 32'h1002);
      chk("bp_rr_held", 32'(a_rr), 32'd2);
    end
    a_ready = 1'b1;
    next_valid(1'b0, e);
    chk("bp_resume_gap", 32'(e), 32'd2);
    chk("bp_resume_index", 32'(a_oi), 32'd3);
    next_valid(1'b0, e);
    next_valid(1'b0, e);
    chk("abort_at_index", 32'(a_oi), 32'd5);

    // Abort together with a handshake at index 5.
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    chk("abort_valid", 32'(a_ov), 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_done", 32'(a_done), 32'd0);
    chk("abort_index_kept", 32'(a_oi), 32'd5);
    chk("abort_data_kept", a_od, 32'h1005);
    chk("abort_rr_kept", 32'(a_rr), 32'd5);
    step();
    chk("abort_no_late_done", 32'(a_done), 32'd0);
    chk("abort_stays_idle", 32'(a_busy), 32'd0);

    // Restart from index 0, then reset mid-sweep at index 17.
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    next_valid(1'b0, e);
    chk("restart_index", 32'(a_oi), 32'd0);
    chk("restart_data", a_od, 32'h1000);
    for (int i = 0; i < 17; i++) next_valid(1'b0, e);
    chk("pre_rst_index", 32'(a_oi), 32'd17);
    rst = 1'b1;
    a_start = 1'b1;
    step();
    rst = 1'b0;
    a_start = 1'b0;
    chk("mid_rst_rr", 32'(a_rr), 32'd0);
    chk("mid_rst_valid", 32'(a_ov), 32'd0);
    chk("mid_rst_data", a_od, 32'd0);
    chk("mid_rst_index", 32'(a_oi), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_done", 32'(a_done), 32'd0);
    step();
    chk("rst_start_ignored", 32'(a_busy), 32'd0);
    chk("rst_start_no_valid", 32'(a_ov), 32'd0);

    // Start while busy is ignored; Start in the Done cycle begins a new sweep.
    full_sweep_a(1'b1);
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    chk("done_start_busy", 32'(a_busy), 32'd1);
    chk("done_start_rr", 32'(a_rr), 32'd0);
    chk("done_start_no_done", 32'(a_done), 32'd0);
    next_valid(1'b0, e);
    chk("done_start_latency", 32'(e + 1), 32'd2);
    chk("done_start_index", 32'(a_oi), 32'd0);
    chk("done_start_data", a_od, 32'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
